ec_scalar_mult_ctrl: RTL and testbench

EC_SCALAR_MULT_CTRL -- requirements
Module: ec_scalar_mult_ctrl

---
 rtl/ec_scalar_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ec_scalar_mult_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_scalar_mult_ctrl.sv
// ---------------------------------------------------------------------------
// ec_scalar_mult_ctrl
//   Sequencer for k*G on a small prime-field curve. It scans the scalar
//   MSB-first (double-and-add) and hands each real point operation to an
//   external point datapath through a req/ack handshake. Degenerate cases
//   (doubling infinity or a y=0 point, adding to infinity, adding P to -P)
//   are resolved here without touching the datapath.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start_i               one-cycle request, only sampled while idle
//   k_i, gx_i, gy_i       scalar and base point, captured on accepted start
//   busy_o                high from the cycle after acceptance through done
//   done_o                one-cycle completion pulse
//   err_o, inf_o          error / point-at-infinity flags, valid with done
//   rx_o, ry_o            result coordinates (0,0 for infinity or error)
//   dp_req_o, dp_dbl_o    datapath issue pulse and op type (1 = double)
//   dp_ax_o .. dp_by_o    datapath operands, held until dp_ack_i
//   dp_ack_i              datapath result valid (only honoured while waiting)
//   dp_rx_i, dp_ry_i      datapath result
//
// Configuration
//   EC_DP_TIMEOUT_EN      when defined, a 5-bit watchdog aborts a datapath
//                         wait after 16 cycles with err=1, inf=0.
// ---------------------------------------------------------------------------
module ec_scalar_mult_ctrl #(
    parameter int W       = 8,
    parameter int KW      = 5,
    parameter int N_ORDER = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [KW-1:0] k_i,
    input  logic [W-1:0]  gx_i,
    input  logic [W-1:0]  gy_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          inf_o,
    output logic [W-1:0]  rx_o,
    output logic [W-1:0]  ry_o,
    output logic          dp_req_o,
    output logic          dp_dbl_o,
    output logic [W-1:0]  dp_ax_o,
    output logic [W-1:0]  dp_ay_o,
    output logic [W-1:0]  dp_bx_o,
    output logic [W-1:0]  dp_by_o,
    input  logic          dp_ack_i,
    input  logic [W-1:0]  dp_rx_i,
    input  logic [W-1:0]  dp_ry_i
);

    localparam int            IW      = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(KW - 1);
    localparam logic [KW:0]   N_LIMIT = (KW + 1)'(N_ORDER);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DBL_REQ, S_DBL_WAIT,
        S_ADD_REQ, S_ADD_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [W-1:0]  gx_q, gy_q;
    logic [W-1:0]  acc_x_q, acc_y_q;
    logic          acc_inf_q;
    logic [IW-1:0] idx_q;
    logic          busy_q, done_q, err_q, inf_q;
    logic [W-1:0]  rx_q, ry_q;
    logic          dp_req_q, dp_dbl_q;
    logic [W-1:0]  dp_ax_q, dp_ay_q, dp_bx_q, dp_by_q;
`ifdef EC_DP_TIMEOUT_EN
    logic [4:0]    wd_q;
`endif

    // NOTE: every register here is sequential state, so all updates use
    // non-blocking assignments; blocking ones would let later statements see
    // this cycle's new values and break the one-edge-per-step behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            acc_inf_q <= 1'b1;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            inf_q     <= 1'b0;
            rx_q      <= '0;
            ry_q      <= '0;
            dp_req_q  <= 1'b0;
            dp_dbl_q  <= 1'b0;
            dp_ax_q   <= '0;
            dp_ay_q   <= '0;
            dp_bx_q   <= '0;
            dp_by_q   <= '0;
`ifdef EC_DP_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            // Pulses default low; the states that raise them override below.
            done_q   <= 1'b0;
            dp_req_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_q     <= k_i;
                        gx_q    <= gx_i;
                        gy_q    <= gy_i;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        inf_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    acc_inf_q <= 1'b1;
                    idx_q     <= TOP_IDX;
                    if ({1'b0, k_q} >= N_LIMIT || k_q == '0) begin
                        // Out-of-range scalar is an error; k=0 is infinity.
                        err_q   <= (k_q != '0);
                        inf_q   <= (k_q == '0);
                        rx_q    <= '0;
                        ry_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_DBL_REQ;
                    end
                end

                S_DBL_REQ: begin
                    if (acc_inf_q || acc_y_q == '0) begin
                        // 2*O = O and 2*(x,0) = O: no datapath work needed.
                        acc_inf_q <= 1'b1;
                        state_q   <= S_ADD_REQ;
                    end else begin
                        dp_req_q <= 1'b1;
                        dp_dbl_q <= 1'b1;
                        dp_ax_q  <= acc_x_q;
                        dp_ay_q  <= acc_y_q;
                        state_q  <= S_DBL_WAIT;
`ifdef EC_DP_TIMEOUT_EN
                        wd_q     <= '0;
`endif
                    end
                end

                S_ADD_REQ: begin
                    if (!k_q[idx_q]) begin
                        state_q <= S_NEXT;
                    end else if (acc_inf_q) begin
                        acc_x_q   <= gx_q;
                        acc_y_q   <= gy_q;
                        acc_inf_q <= 1'b0;
                        state_q   <= S_NEXT;
                    end else if (acc_x_q == gx_q && acc_y_q != gy_q) begin
                        // acc = -G, so acc + G is the point at infinity.
                        acc_inf_q <= 1'b1;
                        state_q   <= S_NEXT;
                    end else begin
                        // acc = G needs the doubling formula, not the chord.
                        dp_req_q <= 1'b1;
                        dp_dbl_q <= (acc_x_q == gx_q);
                        dp_ax_q  <= acc_x_q;
                        dp_ay_q  <= acc_y_q;
                        dp_bx_q  <= gx_q;
                        dp_by_q  <= gy_q;
                        state_q  <= S_ADD_WAIT;
`ifdef EC_DP_TIMEOUT_EN
                        wd_q     <= '0;
`endif
                    end
                end

                S_DBL_WAIT, S_ADD_WAIT: begin
                    if (dp_ack_i) begin
                        acc_x_q   <= dp_rx_i;
                        acc_y_q   <= dp_ry_i;
                        acc_inf_q <= 1'b0;
                        state_q   <= (state_q == S_DBL_WAIT) ? S_ADD_REQ : S_NEXT;
                    end
`ifdef EC_DP_TIMEOUT_EN
                    else if (wd_q == 5'd15) begin
                        // Sixteenth silent cycle: give up on the datapath.
                        err_q   <= 1'b1;
                        inf_q   <= 1'b0;
                        rx_q    <= '0;
                        ry_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wd_q <= wd_q + 5'd1;
                    end
`endif
                end

                S_NEXT: begin
                    if (idx_q == '0) begin
                        inf_q   <= acc_inf_q;
                        rx_q    <= acc_inf_q ? '0 : acc_x_q;
                        ry_q    <= acc_inf_q ? '0 : acc_y_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= S_DBL_REQ;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign inf_o    = inf_q;
    assign rx_o     = rx_q;
    assign ry_o     = ry_q;
    assign dp_req_o = dp_req_q;
    assign dp_dbl_o = dp_dbl_q;
    assign dp_ax_o  = dp_ax_q;
    assign dp_ay_o  = dp_ay_q;
    assign dp_bx_o  = dp_bx_q;
    assign dp_by_o  = dp_by_q;

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ec_scalar_mult_ctrl
//   Self-checking bench. The reference computes k*G by repeated group
//   addition on y^2 = x^3 + 2x + 2 over GF(17); a responder plays the point
//   datapath with random ack delays. One monitor compares every done pulse
//   against a queue of expected results.
// ---------------------------------------------------------------------------
module tb_ec_scalar_mult_ctrl;

    localparam int W = 8, KW = 5, N_ORDER = 19, P = 17;

    typedef struct packed { bit inf; int x; int y; } pt_t;
    typedef struct packed { bit err; bit inf; int x; int y; } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [KW-1:0] k_i = '0;
    logic [W-1:0]  gx_i = '0, gy_i = '0;
    logic          busy_o, done_o, err_o, inf_o;
    logic [W-1:0]  rx_o, ry_o;
    logic          dp_req_o, dp_dbl_o;
    logic [W-1:0]  dp_ax_o, dp_ay_o, dp_bx_o, dp_by_o;
    logic          dp_ack_i;
    logic [W-1:0]  dp_rx_i = '0, dp_ry_i = '0;
    logic          resp_ack = 1'b0, stray_ack = 1'b0;

    assign dp_ack_i = resp_ack | stray_ack;

    ec_scalar_mult_ctrl #(.W(W), .KW(KW), .N_ORDER(N_ORDER)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .k_i(k_i),
        .gx_i(gx_i), .gy_i(gy_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .inf_o(inf_o), .rx_o(rx_o), .ry_o(ry_o),
        .dp_req_o(dp_req_o), .dp_dbl_o(dp_dbl_o), .dp_ax_o(dp_ax_o),
        .dp_ay_o(dp_ay_o), .dp_bx_o(dp_bx_o), .dp_by_o(dp_by_o),
        .dp_ack_i(dp_ack_i), .dp_rx_i(dp_rx_i), .dp_ry_i(dp_ry_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, req_cnt = 0, last_req_cyc = 0, done_cnt = 0, done_cyc = 0;
    int wait_cnt = 0, max_delay = 0;
    bit hold_ack = 1'b0, req_prev = 1'b0;
    res_t exp_q[$];
    pt_t g0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_checks++;
        if (act > lim) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
        end
    endtask

    // ---------------- reference model: plain group arithmetic ----------------
    function automatic int inv17(input int a);
        for (int i = 1; i < P; i++) if ((a * i) % P == 1) return i;
        return 0;
    endfunction

    function automatic pt_t ec_add(input pt_t p1, input pt_t p2);
        pt_t r;
        int lam, x3;
        if (p1.inf) return p2;
        if (p2.inf) return p1;
        r.inf = 1'b1; r.x = 0; r.y = 0;
        if (p1.x == p2.x && (p1.y + p2.y) % P == 0) return r;
        if (p1.x == p2.x)
            lam = ((3 * p1.x * p1.x + 2) % P) * inv17((2 * p1.y) % P) % P;
        else
            lam = ((p2.y - p1.y + P) % P) * inv17((p2.x - p1.x + P) % P) % P;
        x3 = (lam * lam + 2 * P - p1.x - p2.x) % P;
        r.inf = 1'b0;
        r.x = x3;
        r.y = (lam * ((p1.x - x3 + P) % P) % P + P - p1.y) % P;
        return r;
    endfunction

    function automatic pt_t smul(input int k, input pt_t g);
        pt_t r;
        r.inf = 1'b1; r.x = 0; r.y = 0;
        for (int i = 0; i < k; i++) r = ec_add(r, g);
        return r;
    endfunction

    function automatic res_t expect_of(input int k, input pt_t g);
        res_t e;
        pt_t r;
        e.err = 1'b0; e.inf = 1'b0; e.x = 0; e.y = 0;
        if (k >= N_ORDER) begin
            e.err = 1'b1;
        end else begin
            r = smul(k, g);
            e.inf = r.inf;
            e.x = r.inf ? 0 : r.x;
            e.y = r.inf ? 0 : r.y;
        end
        return e;
    endfunction

    // ---------------- observers ----------------
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dp_req_o) begin
            req_cnt++;
            last_req_cyc = cyc;
            check("dp_req single-cycle", int'(req_prev), 0);
        end
        if (!busy_o) check("dp_req while idle", int'(dp_req_o), 0);
        req_prev = dp_req_o;
    end

    always @(negedge clk) begin
        res_t e;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy with done", int'(busy_o), 1);
            if (exp_q.size() == 0) begin
                check("unexpected done", int'(done_o), 0);
            end else begin
                e = exp_q.pop_front();
                check("err at done", int'(err_o), int'(e.err));
                check("inf at done", int'(inf_o), int'(e.inf));
                check("rx at done", int'(rx_o), e.x);
                check("ry at done", int'(ry_o), e.y);
            end
        end
    end

    // Point-datapath stand-in: answers each request after 0..max_delay cycles.
    initial begin
        pt_t a, b, r;
        int d;
        forever begin
            @(negedge clk);
            if (dp_req_o && !hold_ack && !reset) begin
                a.inf = 1'b0; a.x = int'(dp_ax_o); a.y = int'(dp_ay_o);
                b.inf = 1'b0; b.x = int'(dp_bx_o); b.y = int'(dp_by_o);
                r = dp_dbl_o ? ec_add(a, a) : ec_add(a, b);
                if (!dp_dbl_o) check("add with distinct x", int'(dp_ax_o != dp_bx_o), 1);
                wait_cnt++;
                d = $urandom_range(0, max_delay);
                repeat (d) begin
                    @(negedge clk);
                    wait_cnt++;
                    check("operand held", int'(dp_ax_o), a.x);
                end
                resp_ack = 1'b1;
                dp_rx_i  = W'(r.x);
                dp_ry_i  = W'(r.y);
                @(negedge clk);
                resp_ack = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs();
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset err", int'(err_o), 0);
        check("reset inf", int'(inf_o), 0);
        check("reset rx", int'(rx_o), 0);
        check("reset ry", int'(ry_o), 0);
        check("reset dp_req", int'(dp_req_o), 0);
        check("reset dp_dbl", int'(dp_dbl_o), 0);
        check("reset dp_a", int'({dp_ax_o, dp_ay_o}), 0);
        check("reset dp_b", int'({dp_bx_o, dp_by_o}), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int kk, input pt_t g);
        k_i = KW'(kk); gx_i = W'(g.x); gy_i = W'(g.y);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Runs one k*G job; exp_reqs < 0 means the request count is not pinned.
    task automatic run_op(input int kk, input pt_t g, input int max_d,
                          input bit spam, input int exp_reqs);
        int req0, done0, wait0, c0, t;
        exp_q.push_back(expect_of(kk, g));
        max_delay = max_d;
        req0 = req_cnt; done0 = done_cnt; wait0 = wait_cnt; c0 = cyc;
        pulse_start(kk, g);
        check("busy after accept", int'(busy_o), 1);
        t = 0;
        while (done_cnt == done0 && t < 2000) begin
            if (spam) begin
                start_i = 1'($urandom_range(0, 1));
                k_i = KW'($urandom);
                gx_i = W'($urandom);
            end
            @(negedge clk);
            t++;
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("single done", done_cnt - done0, 1);
        check("busy after done", int'(busy_o), 0);
        check_le("latency excl. datapath wait", done_cyc - c0 - (wait_cnt - wait0), 4 * KW + 3);
        if (exp_reqs >= 0) check("dp_req count", req_cnt - req0, exp_reqs);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        pt_t m, bp;
        int j, kk;
        g0.inf = 1'b0; g0.x = 5; g0.y = 1;

        // Model pins: hand-derived multiples of G=(5,1).
        m = smul(2, g0);  check("model 2G", m.x * 100 + m.y, 603);
        m = smul(3, g0);  check("model 3G", m.x * 100 + m.y, 1006);
        m = smul(7, g0);  check("model 7G", m.x * 100 + m.y, 6);
        m = smul(18, g0); check("model 18G", m.x * 100 + m.y, 516);
        m = smul(19, g0); check("model 19G is infinity", int'(m.inf), 1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        run_op(1, g0, 1, 1'b0, 0);
        check("k=1 rx", int'(rx_o), 5);
        check("k=1 ry", int'(ry_o), 1);
        run_op(2, g0, 3, 1'b0, -1);
        check("k=2 result", int'(rx_o) * 100 + int'(ry_o), 603);
        run_op(3, g0, 0, 1'b0, -1);
        check("k=3 result", int'(rx_o) * 100 + int'(ry_o), 1006);
        run_op(18, g0, 2, 1'b0, -1);
        check("k=18 result", int'(rx_o) * 100 + int'(ry_o), 516);
        run_op(0, g0, 0, 1'b0, 0);
        check("k=0 inf held", int'(inf_o), 1);
        run_op(19, g0, 0, 1'b0, 0);
        check("k=19 err held", int'(err_o), 1);
        run_op(31, g0, 0, 1'b0, 0);
        run_op(7, g0, 10, 1'b1, -1);
        check("k=7 result", int'(rx_o) * 100 + int'(ry_o), 6);

        // Abort during the first doubling wait, then a stray ack.
        hold_ack = 1'b1;
        j = req_cnt;
        pulse_start(7, g0);
        for (int i = 0; i < 100 && req_cnt == j; i++) @(negedge clk);
        check("reached datapath wait", req_cnt - j, 1);
        @(negedge clk);
        j = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs();
        check("no done after abort", done_cnt - j, 0);

`ifdef EC_DP_TIMEOUT_EN
        // Watchdog: ack withheld on the final doubling of k=3.
        exp_q.push_back(res_t'{err: 1'b1, inf: 1'b0, x: 0, y: 0});
        j = done_cnt;
        pulse_start(3, g0);
        for (int i = 0; i < 200 && done_cnt == j; i++) @(negedge clk);
        check("timeout done", done_cnt - j, 1);
        check("timeout cycles after wait entry", done_cyc - last_req_cyc, 16);
        @(negedge clk);
        hold_ack = 1'b0;
`else
        // Without the watchdog the wait is indefinite.
        j = done_cnt;
        pulse_start(3, g0);
        repeat (40) @(negedge clk);
        check("still busy without ack", int'(busy_o), 1);
        check("no done without ack", done_cnt - j, 0);
        hold_ack = 1'b0;
        do_reset();
`endif

        // Random jobs on random base points jG (all of order 19).
        for (int n = 0; n < 24; n++) begin
            j = $urandom_range(1, 18);
            bp = smul(j, g0);
            kk = (n % 6 == 5) ? $urandom_range(19, 31) : $urandom_range(0, 18);
            run_op(kk, bp, $urandom_range(0, 10), 1'($urandom_range(0, 1)), -1);
        end

        check("expected queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit: got timeout, expected completion");
        $fatal(1);
    end

endmodule
